// File: rtl/iot_stream_pkg.sv
// Shared widths and serializer state type for the IoT byte-stream transmitter.
package iot_stream_pkg;
  localparam int WORD_W         = 128;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 16;
  localparam int IDX_W          = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;
endpackage

// File: rtl/iot_stream_if.sv
// Producer push port plus IOTDF byte port; master = environment, slave = transmitter.
interface iot_stream_if #(parameter int CNT_W = 16);
  logic                               wr_valid;
  logic [iot_stream_pkg::WORD_W-1:0]  wr_data;
  logic                               wr_ready;
  logic                               busy;
  logic                               in_en;
  logic [iot_stream_pkg::BYTE_W-1:0]  iot_in;
  logic                               idle;
  logic [CNT_W-1:0]                   sent_cnt;

  modport master (
    output wr_valid, wr_data, busy,
    input  wr_ready, in_en, iot_in, idle, sent_cnt
  );

  modport slave (
    input  wr_valid, wr_data, busy,
    output wr_ready, in_en, iot_in, idle, sent_cnt
  );
endinterface

// File: rtl/iot_word_fifo.sv
// Word FIFO with synchronous write and show-ahead read; caller gates push/pop.
module iot_word_fifo
  import iot_stream_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WORD_W-1:0] din,
  input  logic              pop,
  output logic [WORD_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;

  assign wptr_d = push ? wptr_q + 1'b1 : wptr_q;
  assign rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= din;
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign dout  = mem_q[rptr_q[AW-1:0]];
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
endmodule

// File: rtl/iot_stream_tx.sv
// Buffers 128-bit samples and serializes them MSB-first onto the IOTDF byte port.
//   state | meaning
//   IDLE  | no partial word; byte 0 of the FIFO head goes out on the next free edge
//   SEND  | bytes idx_q..15 of the current word still pending in shift_q
module iot_stream_tx
  import iot_stream_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        rst,
  iot_stream_if.slave bus
);
  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] shift_q;
  logic              in_en_q;
  logic [BYTE_W-1:0] iot_in_q;
  logic [CNT_W-1:0]  sent_cnt_q;

  logic [WORD_W-1:0] head;
  logic              full, empty, push, pop;

  assign push = bus.wr_valid && !full;
  assign pop  = !bus.busy && (state_q == IDLE) && !empty;

  iot_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (bus.wr_data),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      shift_q    <= '0;
      in_en_q    <= 1'b0;
      iot_in_q   <= '0;
      sent_cnt_q <= '0;
    end else if (bus.busy) begin
      in_en_q  <= 1'b0;
      iot_in_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            in_en_q  <= 1'b1;
            iot_in_q <= head[WORD_W-1 -: BYTE_W];
            shift_q  <= {head[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            idx_q    <= IDX_W'(1);
            state_q  <= SEND;
          end else begin
            in_en_q  <= 1'b0;
            iot_in_q <= '0;
          end
        end
        SEND: begin
          in_en_q  <= 1'b1;
          iot_in_q <= shift_q[WORD_W-1 -: BYTE_W];
          shift_q  <= shift_q << BYTE_W;
          if (idx_q == IDX_W'(BYTES_PER_WORD - 1)) begin
            idx_q      <= '0;
            state_q    <= IDLE;
            sent_cnt_q <= sent_cnt_q + 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.wr_ready = !full;
  assign bus.in_en    = in_en_q;
  assign bus.iot_in   = iot_in_q;
  assign bus.sent_cnt = sent_cnt_q;
  assign bus.idle     = empty && (state_q == IDLE);
endmodule

// File: tb/tb_iot_stream_tx.sv
// Self-checking bench: directed table, hand sequences and random traffic vs a queue model.
module tb_iot_stream_tx;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iot_stream_if #(.CNT_W(CNT_W)) bus();

  iot_stream_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of buffered words plus the bytes still owed from the current word.
  logic [127:0] fifo_m[$];
  logic [7:0]   pend_m[$];
  int           cnt_m;

  logic         last_en;
  logic [7:0]   last_byte;
  logic         last_acc;

  typedef struct {
    logic         v;
    logic [127:0] d;
    logic         b;
    logic         e_en;
    logic [7:0]   e_byte;
    logic         e_idle;
    logic [15:0]  e_cnt;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    fifo_m.delete();
    pend_m.delete();
    cnt_m = 0;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic v, input logic [127:0] d, input logic b);
    logic         exp_en;
    logic [7:0]   exp_byte;
    logic [127:0] w;
    bus.wr_valid = v;
    bus.wr_data  = d;
    bus.busy     = b;
    #1;
    chk("wr_ready", 128'(bus.wr_ready), 128'(fifo_m.size() < DEPTH));
    last_acc = v && (fifo_m.size() < DEPTH);
    exp_en   = 1'b0;
    exp_byte = 8'h00;
    if (!b) begin
      if (pend_m.size() == 0 && fifo_m.size() > 0) begin
        w = fifo_m.pop_front();
        for (int j = 0; j < 16; j++) pend_m.push_back(w[127-8*j -: 8]);
      end
      if (pend_m.size() > 0) begin
        exp_en   = 1'b1;
        exp_byte = pend_m.pop_front();
        if (pend_m.size() == 0) cnt_m = (cnt_m + 1) % (1 << CNT_W);
      end
    end
    if (last_acc) fifo_m.push_back(d);
    @(posedge clk);
    #1;
    chk("in_en", 128'(bus.in_en), 128'(exp_en));
    chk("iot_in", 128'(bus.iot_in), 128'(exp_byte));
    chk("sent_cnt", 128'(bus.sent_cnt), 128'(cnt_m));
    chk("idle", 128'(bus.idle), 128'(fifo_m.size() == 0 && pend_m.size() == 0));
    last_en   = bus.in_en;
    last_byte = bus.iot_in;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_en"}, 128'(bus.in_en), 128'(0));
    chk({tag, "_iot_in"}, 128'(bus.iot_in), 128'(0));
    chk({tag, "_cnt"}, 128'(bus.sent_cnt), 128'(0));
    chk({tag, "_idle"}, 128'(bus.idle), 128'(1));
    chk({tag, "_wr_ready"}, 128'(bus.wr_ready), 128'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.busy     = 1'b0;
    #1;
    check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  function automatic logic [127:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] w0, wa, wb, wc;
    logic [127:0] words[96];
    int en_cnt, nw, busy_left, last_cnt, cyc;
    logic [7:0] b17;

    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.busy     = 1'b0;
    model_clear();
    #2;
    check_reset_outputs("por");
    do_reset();

    // Directed table: one word 00..0F, no stalls.
    for (int j = 0; j < 16; j++) w0[127-8*j -: 8] = 8'(j);
    tbl[0] = '{v: 1'b1, d: w0, b: 1'b0, e_en: 1'b0, e_byte: 8'h00, e_idle: 1'b0, e_cnt: 16'd0};
    for (int i = 1; i <= 16; i++)
      tbl[i] = '{v: 1'b0, d: '0, b: 1'b0, e_en: 1'b1, e_byte: 8'(i-1),
                 e_idle: (i == 16), e_cnt: (i == 16) ? 16'd1 : 16'd0};
    tbl[17] = '{v: 1'b0, d: '0, b: 1'b0, e_en: 1'b0, e_byte: 8'h00, e_idle: 1'b1, e_cnt: 16'd1};
    for (int i = 0; i < 18; i++) begin
      bus.wr_valid = tbl[i].v;
      bus.wr_data  = tbl[i].d;
      bus.busy     = tbl[i].b;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_en", i), 128'(bus.in_en), 128'(tbl[i].e_en));
      chk($sformatf("tbl%0d_byte", i), 128'(bus.iot_in), 128'(tbl[i].e_byte));
      chk($sformatf("tbl%0d_idle", i), 128'(bus.idle), 128'(tbl[i].e_idle));
      chk($sformatf("tbl%0d_cnt", i), 128'(bus.sent_cnt), 128'(tbl[i].e_cnt));
      @(negedge clk);
    end

    // Two words back to back: 32 contiguous bytes.
    do_reset();
    wa = rand_word();
    wb = rand_word();
    en_cnt = 0;
    step(1'b1, wa, 1'b0);
    step(1'b1, wb, 1'b0);
    en_cnt += int'(last_en);
    for (int k = 1; k <= 31; k++) begin
      step(1'b0, '0, 1'b0);
      en_cnt += int'(last_en);
      if (k == 16) b17 = last_byte;
    end
    chk("b2b_contig", 128'(en_cnt), 128'(32));
    chk("b2b_byte17", 128'(b17), 128'(wb[127:120]));
    chk("b2b_cnt", 128'(bus.sent_cnt), 128'(2));
    step(1'b0, '0, 1'b0);

    // Stall for 3 edges with byte 7 next.
    do_reset();
    wa = rand_word();
    step(1'b1, wa, 1'b0);
    repeat (7) step(1'b0, '0, 1'b0);
    en_cnt = 0;
    repeat (3) begin
      step(1'b0, '0, 1'b1);
      en_cnt += int'(last_en);
    end
    chk("stall_en", 128'(en_cnt), 128'(0));
    step(1'b0, '0, 1'b0);
    chk("stall_resume", 128'(last_byte), 128'(wa[71:64]));
    repeat (9) step(1'b0, '0, 1'b0);
    chk("stall_cnt", 128'(bus.sent_cnt), 128'(1));

    // Fill under busy: 5th push refused, then 64 contiguous bytes.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, rand_word(), 1'b1);
      chk($sformatf("fill_acc%0d", i), 128'(last_acc), 128'(i < 4));
    end
    chk("full_ready", 128'(bus.wr_ready), 128'(0));
    en_cnt = 0;
    repeat (64) begin
      step(1'b0, '0, 1'b0);
      en_cnt += int'(last_en);
    end
    chk("drain_contig", 128'(en_cnt), 128'(64));
    chk("drain_ready", 128'(bus.wr_ready), 128'(1));
    chk("drain_cnt", 128'(bus.sent_cnt), 128'(4));

    // Reset while byte 9 is on the port and two words are queued.
    do_reset();
    wa = rand_word(); wb = rand_word(); wc = rand_word();
    step(1'b1, wa, 1'b0);
    step(1'b1, wb, 1'b0);
    step(1'b1, wc, 1'b0);
    repeat (8) step(1'b0, '0, 1'b0);
    chk("pre_rst_byte9", 128'(last_byte), 128'(wa[55:48]));
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_en", 128'(bus.in_en), 128'(0));
    chk("midrst_byte", 128'(bus.iot_in), 128'(0));
    chk("midrst_idle", 128'(bus.idle), 128'(1));
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (5) step(1'b0, '0, 1'b0);

    // IOTDF frame: 96 words, 2-cycle busy pulse after every 8th completed word.
    do_reset();
    for (int i = 0; i < 96; i++) words[i] = rand_word();
    nw = 0; busy_left = 0; last_cnt = 0; cyc = 0;
    while (cnt_m < 96 && cyc < 5000) begin
      step(nw < 96, (nw < 96) ? words[nw] : '0, busy_left > 0);
      if (last_acc) nw++;
      if (busy_left > 0) busy_left--;
      if (cnt_m != last_cnt && cnt_m % 8 == 0) busy_left = 2;
      last_cnt = cnt_m;
      cyc++;
    end
    if (cyc >= 5000) begin
      n_cmp++; n_bad++;
      $display("FAIL frame_timeout: got %0d words expected 96", cnt_m);
    end
    chk("frame_cnt", 128'(bus.sent_cnt), 128'(96));

    // Random traffic.
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 1)), rand_word(), ($urandom_range(0, 3) == 0));
    repeat (80) step(1'b0, '0, 1'b0);
    chk("rand_idle", 128'(bus.idle), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/iot_stream_tx.md
Name: iot_stream_tx

Overview:
Byte-stream transmitter that feeds the IOTDF input port. Producers (stimulus sequencers, DMA, host bridge) push 128-bit IoT samples through a valid/ready interface into a small FIFO. The block serializes each sample MSB-first into 16 bytes on in_en/iot_in. It stalls on the consumer's busy flag with exactly the cycle semantics the IOTDF input side expects.

Parameters:
DEPTH, 4, FIFO depth in 128-bit words (power of 2, >=2)
CNT_W, 16, width of the completed-word counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
wr_valid  in  1  producer has a word on wr_data
wr_data  in  128  sample word; bits [127:120] are sent first
wr_ready  out  1  FIFO can accept a word (= !full)
busy  in  1  IOTDF busy; when sampled high at an edge, no byte is driven for that cycle
in_en  out  1  registered byte strobe to IOTDF
iot_in  out  8  registered byte to IOTDF
idle  out  1  FIFO empty and no partial word outstanding
sent_cnt  out  CNT_W  number of fully transmitted words, wraps

Behaviour:
- Reset is asynchronous and active-high.
- Reset values: in_en=0, iot_in=8'h00, sent_cnt=0, FIFO empty, state IDLE, byte index=0. During and after reset: wr_ready=1, idle=1.
- Push: an edge with wr_valid && wr_ready writes wr_data into the FIFO. A push while full cannot occur, because wr_ready is low. There is no bypass: a word pushed at edge k is first eligible to drive at edge k+1.
- Byte j of a word (j=0..15) is word[127-8j -: 8].
- States:
  - IDLE: no partial word.
  - SEND: byte index 1..15 pending in the shift register.
- Per-edge decision, using busy as sampled at that edge:
  - busy=1: in_en<=0, iot_in<=0. State, index, FIFO and counters hold.
  - busy=0, IDLE, FIFO non-empty: pop the head. Drive byte 0 directly from the head (in_en<=1). Load the shift register and set index to 1. Go to SEND.
  - busy=0, IDLE, FIFO empty: in_en<=0, iot_in<=0.
  - busy=0, SEND, index<15: drive byte[index] and increment index.
  - busy=0, SEND, index=15: drive byte 15, sent_cnt+1 (wraps at 2^CNT_W), go to IDLE.
- The next word's byte 0 can be driven on the edge immediately after byte 15. Back-to-back words have no gap.
- A push and a pop on the same edge are legal at any occupancy except full, where no push occurs. Occupancy changes by push minus pop.
- busy may rise or fall on any edge, including mid-word or on byte 0/15. A stall never skips or repeats a byte.
- iot_in is forced to 0 whenever in_en=0.
- idle = FIFO empty && state==IDLE (combinational).
- Asynchronous reset mid-word: partial word and FIFO contents are discarded, outputs return to reset values immediately, and sent_cnt clears.

Decomposition:
- Package iot_stream_pkg:
  - WORD_W=128, BYTE_W=8, BYTES_PER_WORD=16, IDX_W=4
  - state enum {IDLE, SEND}
- One sub-module: iot_word_fifo.
  - Synchronous-write, show-ahead read.
  - Ports: clk, rst, push, din, pop, dout, full, empty.
  - The serializer FSM, index, shift register and counter live in iot_stream_tx.

Test Plan:
- One word 0x000102…0F, busy=0 → in_en high for 16 consecutive cycles starting the edge after the push. iot_in=0x00,0x01…0x0F. Then in_en=0, sent_cnt=1, idle=1.
- Two words pushed on consecutive edges, busy=0 → 32 contiguous in_en cycles. The 17th byte is the second word's [127:120], and sent_cnt=2.
- busy high for 3 edges while byte index=7 is next → in_en=0 and iot_in=0 for exactly 3 cycles. Output resumes with byte 7, and all 16 bytes arrive in order.
- busy held high, push 5 words → wr_ready drops after the 4th push (DEPTH=4), and the 5th is refused. Release busy → 64 contiguous bytes, then wr_ready=1 again.
- Assert rst while byte 9 of a word is driven and 2 words are queued → in_en=0 and iot_in=0 immediately. After release: idle=1, sent_cnt=0, and no bytes until a new push.
- 96 sequential words (IOTDF frame), busy pulsed 2 cycles after every 8th word → sent_cnt=96. The byte stream matches the words MSB-first, with no loss or duplication.
